// File: rtl/adxl362_spi_master.sv
// adxl362_spi_master: turns single-register read/write requests into ADXL362
// SPI frames (mode 0, MSB first) on sclk/mosi/miso/ncs.
// Optional feature macro: ADXL362_SPI_FIFO_CMD_EN. When defined, op=10 issues
// the FIFO read command 0x0D as a 16-bit frame. Otherwise op=10 is rejected.
// Handshake: start acts as valid and ready as ready. A request transfers in the
// cycle where start=1 and ready=1. start while ready=0 is dropped silently.
// err and rdata_valid are single-cycle pulses with no backpressure.
module adxl362_spi_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_IDLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       err,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       ncs
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // The gap state covers CS_IDLE-1 cycles. ready then rises in the last
  // ncs-high cycle, so a start held high gives exactly CS_IDLE cycles of ncs
  // high between frames.
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'((CS_IDLE >= 2) ? CS_IDLE - 2 : 0);

  state_t      state, state_nx;
  logic [15:0] cnt;
  logic [4:0]  bit_cnt;
  logic [23:0] tx_sr;
  logic [7:0]  rx_sr;
  logic        sclk_q;
  logic        is_read;
  logic        accept;
  logic        reject;
  logic        div_end;
  logic        op_legal;
  logic [23:0] load_word;
  logic [4:0]  load_bits;

  assign div_end = (cnt == DIV_LAST);

  // Decode the request into its frame contents and legality.
  always_comb begin
    op_legal  = 1'b0;
    load_word = '0;
    load_bits = 5'd24;
    case (op)
      2'b00: begin
        op_legal  = 1'b1;
        load_word = {8'h0A, addr, wdata};
      end
      2'b01: begin
        op_legal  = 1'b1;
        load_word = {8'h0B, addr, wdata};
      end
`ifdef ADXL362_SPI_FIFO_CMD_EN
      2'b10: begin
        op_legal  = 1'b1;
        load_word = {8'h0D, 16'h0000};
        load_bits = 5'd16;
      end
`endif
      default: op_legal = 1'b0;
    endcase
  end

  // Next-state logic plus the accept/reject strobes.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    reject   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (op_legal) begin
            accept   = 1'b1;
            state_nx = SHIFT;
          end else begin
            reject = 1'b1;
          end
        end
      end
      SHIFT: if (div_end && sclk_q && bit_cnt == 5'd1) state_nx = HOLD;
      HOLD:  if (div_end) state_nx = (CS_IDLE >= 2) ? GAP : IDLE;
      GAP:   if (cnt == GAP_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Datapath: phase counter, shift registers, and the rdata/err pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      sclk_q      <= 1'b0;
      is_read     <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      err         <= reject;
      if (state == IDLE || state_nx != state || (state == SHIFT && div_end))
        cnt <= '0;
      else
        cnt <= cnt + 16'd1;
      if (accept) begin
        tx_sr   <= load_word;
        bit_cnt <= load_bits;
        is_read <= (op != 2'b00);
        sclk_q  <= 1'b0;
      end
      if (state == SHIFT && div_end) begin
        if (!sclk_q) begin
          sclk_q <= 1'b1;
          rx_sr  <= {rx_sr[6:0], miso};
        end else begin
          sclk_q  <= 1'b0;
          tx_sr   <= {tx_sr[22:0], 1'b0};
          bit_cnt <= bit_cnt - 5'd1;
        end
      end
      if (state == HOLD && div_end && is_read) begin
        rdata       <= rx_sr;
        rdata_valid <= 1'b1;
      end
    end
  end

  assign ncs   = !(state == SHIFT || state == HOLD);
  assign sclk  = sclk_q;
  assign mosi  = (state == SHIFT) ? tx_sr[23] : 1'b0;
  assign ready = (state == IDLE);

endmodule

// File: tb/tb_adxl362_spi_master.sv
// tb_adxl362_spi_master: randomized bench for adxl362_spi_master with a
// frame-level sensor model and an expected-rdata scoreboard.
// Optional feature macro: ADXL362_SPI_FIFO_CMD_EN.
module tb_adxl362_spi_master;
  localparam int CLK_DIV = 4;
  localparam int CS_IDLE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic       ready, rdata_valid, err, sclk, mosi, ncs;
  logic       miso;
  logic [7:0] rdata;

  adxl362_spi_master #(.CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .rdata_valid(rdata_valid), .err(err),
    .sclk(sclk), .mosi(mosi), .miso(miso), .ncs(ncs)
  );

  // Clock.
  always #5 clk = ~clk;

  // Scoreboard state.
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_rdata = 8'h00;

  // Bus observations gathered by the monitor.
  int          frames_started = 0, frames_done = 0;
  int          rises = 0, low_cycles = 0, first_rise_lc = 0, high_run = 0;
  int          gap_q[$];
  logic [31:0] mosi_word = '0;
  logic        prev_ncs = 1'b1, prev_sclk = 1'b0;
  int          idle_mosi_bad = 0, both_bad = 0, err_total = 0, rv_total = 0;
  logic        rv_at_rise = 1'b0;
  logic [23:0] miso_stream = '0;
  int          frame_n = 24;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor and sensor model, sampled on the falling clk edge.
  always @(negedge clk) begin
    if (!ncs) begin
      if (prev_ncs) begin
        frames_started++;
        gap_q.push_back(high_run);
        rises = 0; mosi_word = '0; low_cycles = 0; first_rise_lc = 0;
      end
      low_cycles++;
      if (sclk && !prev_sclk) begin
        rises++;
        mosi_word = {mosi_word[30:0], mosi};
        if (rises == 1) first_rise_lc = low_cycles;
      end
      high_run = 0;
    end else begin
      high_run++;
      if (!prev_ncs) begin
        frames_done++;
        rv_at_rise = rdata_valid;
      end
      if (mosi) idle_mosi_bad++;
    end
    if (rdata_valid) begin
      rv_total++;
      if (exp_q.size() == 0) check("rv_unexpected", 32'd1, 32'd0);
      else check("rdata", {24'h0, rdata}, {24'h0, exp_q.pop_front()});
    end
    if (err) err_total++;
    if (err && rdata_valid) both_bad++;
    // The sensor presents bit number `rises` of its response until sclk rises.
    if (!ncs && rises < frame_n) miso = miso_stream[frame_n - 1 - rises];
    else miso = 1'b0;
    prev_ncs = ncs;
    prev_sclk = sclk;
  end

  function automatic logic [7:0] cmd_of(input logic [1:0] o);
    return (o == 2'b00) ? 8'h0A : (o == 2'b01) ? 8'h0B : 8'h0D;
  endfunction

  task automatic load_response(input int n, input logic [7:0] resp);
    logic [15:0] junk;
    junk = 16'($urandom);
    frame_n = n;
    miso_stream = (n == 24) ? {junk, resp} : {8'h00, junk[7:0], resp};
  endtask

  // One request, followed by checks on the whole frame it produced.
  task automatic run_frame(input logic [1:0] f_op, input logic [7:0] f_addr,
                           input logic [7:0] f_wdata, input logic [7:0] f_resp);
    int n, d0, rv0, e0, s0;
    logic [7:0] cmd;
    n = (f_op == 2'b10) ? 16 : 24;
    cmd = cmd_of(f_op);
    load_response(n, f_resp);
    if (f_op != 2'b00) begin
      exp_q.push_back(f_resp);
      last_rdata = f_resp;
    end
    d0 = frames_done; rv0 = rv_total; e0 = err_total; s0 = frames_started;
    start = 1'b1; op = f_op; addr = f_addr; wdata = f_wdata;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
    check("accept_ready", {31'h0, ready}, 32'd0);
    check("accept_ncs", {31'h0, ncs}, 32'd0);
    check("accept_sclk", {31'h0, sclk}, 32'd0);
    check("accept_mosi", {31'h0, mosi}, {31'h0, cmd[7]});
    for (int i = 0; i < 3000 && frames_done == d0; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 15) == 0);
    end
    start = 1'b0;
    check("frame_done", {31'h0, frames_done != d0}, 32'd1);
    check("one_frame", frames_started - s0, 32'd1);
    check("rises", rises, n);
    if (n == 24) check("mosi_bits", {8'h0, mosi_word[23:0]}, {8'h0, cmd, f_addr, f_wdata});
    else         check("mosi_cmd", {24'h0, mosi_word[15:8]}, {24'h0, cmd});
    check("ncs_low_len", low_cycles, (2 * n + 1) * CLK_DIV);
    check("first_rise", first_rise_lc, CLK_DIV + 1);
    check("rv_at_ncs_rise", {31'h0, rv_at_rise}, {31'h0, f_op != 2'b00});
    check("rv_count", rv_total - rv0, {31'h0, f_op != 2'b00});
    check("no_err_busy", err_total - e0, 32'd0);
    for (int i = 0; i < 50 && !ready; i++) begin @(posedge clk); #1; end
    check("ready_back", {31'h0, ready}, 32'd1);
    check("rdata_hold", {24'h0, rdata}, {24'h0, last_rdata});
    check("q_drained", exp_q.size(), 32'd0);
  endtask

  task automatic illegal(input logic [1:0] f_op);
    int e0, s0;
    e0 = err_total; s0 = frames_started;
    start = 1'b1; op = f_op; addr = 8'($urandom); wdata = 8'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    check("err_pulse", {31'h0, err}, 32'd1);
    check("err_ncs", {31'h0, ncs}, 32'd1);
    check("err_ready", {31'h0, ready}, 32'd1);
    @(posedge clk); #1;
    check("err_one_cycle", {31'h0, err}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("err_count", err_total - e0, 32'd1);
    check("err_no_frame", frames_started - s0, 32'd0);
  endtask

  initial begin
    logic [7:0] r;
    int s0, d0, rv0;

    // Reset.
    @(posedge clk); #1;
    check("rst_ncs", {31'h0, ncs}, 32'd1);
    check("rst_sclk", {31'h0, sclk}, 32'd0);
    check("rst_mosi", {31'h0, mosi}, 32'd0);
    check("rst_ready", {31'h0, ready}, 32'd1);
    check("rst_rdata", {24'h0, rdata}, 32'd0);
    check("rst_rv", {31'h0, rdata_valid}, 32'd0);
    check("rst_err", {31'h0, err}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Directed write and read.
    run_frame(2'b00, 8'h2D, 8'h02, 8'h00);
    run_frame(2'b01, 8'h00, 8'h00, 8'hAD);

    // Illegal ops.
    illegal(2'b11);
`ifdef ADXL362_SPI_FIFO_CMD_EN
    run_frame(2'b10, 8'h00, 8'h00, 8'h5C);
`else
    illegal(2'b10);
`endif

    // Randomized single frames.
    for (int k = 0; k < 8; k++)
      run_frame(2'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));

    // Back-to-back with start held high.
    r = 8'($urandom_range(1, 255));
    load_response(24, r);
    repeat (3) exp_q.push_back(r);
    last_rdata = r;
    gap_q.delete();
    s0 = frames_started;
    start = 1'b1; op = 2'b01; addr = 8'($urandom); wdata = 8'($urandom);
    for (int i = 0; i < 3000 && frames_started < s0 + 3; i++) begin @(posedge clk); #1; end
    start = 1'b0;
    d0 = frames_started;
    for (int i = 0; i < 3000 && frames_done < d0; i++) begin @(posedge clk); #1; end
    repeat (20) @(posedge clk);
    #1;
    check("b2b_frames", frames_started - s0, 32'd3);
    if (gap_q.size() >= 3) begin
      check("b2b_gap1", gap_q[1], CS_IDLE);
      check("b2b_gap2", gap_q[2], CS_IDLE);
    end else begin
      check("b2b_gap_count", gap_q.size(), 32'd3);
    end
    check("b2b_q_drained", exp_q.size(), 32'd0);
    check("b2b_rdata", {24'h0, rdata}, {24'h0, last_rdata});

    // Reset in the middle of a read frame.
    load_response(24, 8'($urandom));
    rv0 = rv_total;
    start = 1'b1; op = 2'b01; addr = 8'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 500 && rises < 10; i++) begin @(posedge clk); #1; end
    check("mid_rises", {31'h0, rises >= 10}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_ncs", {31'h0, ncs}, 32'd1);
    check("mid_rst_sclk", {31'h0, sclk}, 32'd0);
    check("mid_rst_mosi", {31'h0, mosi}, 32'd0);
    check("mid_rst_ready", {31'h0, ready}, 32'd1);
    check("mid_rst_rdata", {24'h0, rdata}, 32'd0);
    rst = 1'b0;
    last_rdata = 8'h00;
    repeat (60) @(posedge clk);
    #1;
    check("mid_rst_no_rv", rv_total - rv0, 32'd0);

    // rst and start together: the start is dropped.
    s0 = frames_started;
    rst = 1'b1; start = 1'b1; op = 2'b01;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst_start_ready", {31'h0, ready}, 32'd1);
    check("rst_start_ncs", {31'h0, ncs}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("rst_start_no_frame", frames_started - s0, 32'd0);

    // Whole-run invariants.
    check("idle_mosi", idle_mosi_bad, 32'd0);
    check("err_and_rv", both_bad, 32'd0);
    check("final_q", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
